// File: rtl/onchip_mem_stream_reader_pkg.sv
// Shared definitions for the on-chip memory stream reader.
// Contents:
//   state_t        - reader FSM states (IDLE, RUN, DRAIN)
//   DEF_*          - default width and depth constants
//   wrap_inc()     - word-address increment with wrap at the memory depth
package onchip_mem_stream_reader_pkg;

    localparam int DEF_ADDR_W     = 17;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_WORDS  = 102400;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Next word address; the last valid word (words-1) wraps back to 0.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] words);
        logic [31:0] nxt;
        if (addr >= (words - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = addr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/onchip_mem_stream_reader_if.sv
// Bundle of the reader's control, memory-bus and stream-source signals.
// Modports:
//   master - the reader: takes start/base_addr/word_count, mem_readdata, src_ready;
//            drives busy/done, the memory address/strobes and the stream source.
//   slave  - the environment (controller, memory and stream sink).
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    // control
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    // memory bus
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    // stream source
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_startofpacket;
    logic              src_endofpacket;

    modport master (
        input  start, base_addr, word_count, mem_readdata, src_ready,
        output busy, done, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_clken, src_data, src_valid, src_startofpacket, src_endofpacket
    );

    modport slave (
        output start, base_addr, word_count, mem_readdata, src_ready,
        input  busy, done, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_clken, src_data, src_valid, src_startofpacket, src_endofpacket
    );

endinterface

// File: rtl/onchip_mem_stream_reader_mem_rd_fifo.sv
// mem_rd_fifo: synchronous FIFO buffering words read from memory.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     - write one entry (caller guarantees not full)
//   pop             - remove the head entry (caller guarantees not empty)
//   rdata           - current head entry
//   valid           - FIFO non-empty
//   count           - number of stored entries
// Push and pop in the same cycle leave count unchanged.
module mem_rd_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign valid = (count_r != {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: reads word_count consecutive words from a
// 1-cycle-latency on-chip memory starting at base_addr (wrapping at
// MEM_WORDS) and streams them out with start/end-of-packet markers.
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous active-high reset; abandons any transfer
//   bus    - master side of onchip_mem_stream_reader_if (control, memory, stream)
// Reads are issued only while buffer occupancy plus outstanding reads is
// below FIFO_DEPTH, so backpressure on the stream never drops a word.
module onchip_mem_stream_reader
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    onchip_mem_stream_reader_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = DATA_W + 2;   // {sop, eop, data}

    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic              cs_r;          // read issued this cycle
    logic              cs_sop_r;
    logic              cs_eop_r;
    logic              pend_r;        // readdata for last cycle's read is on the bus now
    logic              pend_sop_r;
    logic              pend_eop_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   remain_r;      // reads still to issue

    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_valid_s;
    logic [FW-1:0]     fifo_wdata_s;
    logic [FW-1:0]     fifo_rdata_s;
    logic              pop_s;
    logic              final_pop_s;
    logic [CNT_W+1:0]  occupancy_s;
    logic              room_s;

    assign pop_s        = fifo_valid_s & bus.src_ready;
    assign final_pop_s  = pop_s & fifo_rdata_s[DATA_W];
    assign fifo_wdata_s = {pend_sop_r, pend_eop_r, bus.mem_readdata};

    // Outstanding reads: one issued this cycle (cs_r) and one returning now (pend_r).
    assign occupancy_s  = (CNT_W+2)'(fifo_count_s) + (CNT_W+2)'(cs_r) + (CNT_W+2)'(pend_r);
    assign room_s       = (occupancy_s < (CNT_W+2)'(FIFO_DEPTH));

    // Transfer FSM with registered memory strobes and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cs_r       <= 1'b0;
            cs_sop_r   <= 1'b0;
            cs_eop_r   <= 1'b0;
            pend_r     <= 1'b0;
            pend_sop_r <= 1'b0;
            pend_eop_r <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            remain_r   <= {(ADDR_W+1){1'b0}};
        end else begin
            done_r     <= 1'b0;
            pend_r     <= cs_r;
            pend_sop_r <= cs_sop_r;
            pend_eop_r <= cs_eop_r;
            case (state_r)
                ST_IDLE: begin
                    cs_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.word_count != {(ADDR_W+1){1'b0}}) begin
                            // First read goes out in the first RUN cycle.
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                            cs_r     <= 1'b1;
                            cs_sop_r <= 1'b1;
                            cs_eop_r <= (bus.word_count == (ADDR_W+1)'(1));
                            addr_r   <= bus.base_addr;
                            remain_r <= bus.word_count - (ADDR_W+1)'(1);
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (remain_r == {(ADDR_W+1){1'b0}}) begin
                        cs_r    <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else if (room_s) begin
                        cs_r     <= 1'b1;
                        cs_sop_r <= 1'b0;
                        cs_eop_r <= (remain_r == (ADDR_W+1)'(1));
                        addr_r   <= ADDR_W'(wrap_inc(32'(addr_r), 32'(MEM_WORDS)));
                        remain_r <= remain_r - (ADDR_W+1)'(1);
                    end else begin
                        cs_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    cs_r <= 1'b0;
                    if (final_pop_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cs_r    <= 1'b0;
                end
            endcase
        end
    end

    mem_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pend_r),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .valid (fifo_valid_s),
        .count (fifo_count_s)
    );

    assign bus.busy              = busy_r;
    assign bus.done              = done_r;
    assign bus.mem_address       = addr_r;
    assign bus.mem_chipselect    = cs_r;
    assign bus.mem_write         = 1'b0;
    assign bus.mem_byteenable    = 4'b1111;
    assign bus.mem_clken         = 1'b1;
    assign bus.src_data          = fifo_rdata_s[DATA_W-1:0];
    assign bus.src_valid         = fifo_valid_s;
    // Markers are masked so they never show while the FIFO is empty.
    assign bus.src_startofpacket = fifo_rdata_s[DATA_W+1] & fifo_valid_s;
    assign bus.src_endofpacket   = fifo_rdata_s[DATA_W] & fifo_valid_s;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Testbench for onchip_mem_stream_reader: a table of transfers (base, count,
// sink ready pattern, hand-computed first/last addresses) plus directed
// sequences for zero-length, start-while-busy and reset-mid-transfer.
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 102400;

    logic clk;
    logic reset;

    onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_mem_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Observation logs filled by the monitor.
    int addr_q[$];
    int addr_cyc_q[$];
    int data_q[$];
    int sop_q[$];
    int eop_q[$];
    int first_valid_cyc;
    int last_accept_cyc;
    int done_cyc;
    int done_busy;
    int done_seen;
    int max_count;

    function automatic int mem_word(input int a);
        return 32'h5A00_0000 | a;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read, 1-cycle latency.
    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= mem_word(int'(bus.mem_address));
    end

    // Monitor sampling between active edges.
    always @(negedge clk) begin
        if (bus.mem_chipselect) begin
            addr_q.push_back(int'(bus.mem_address));
            addr_cyc_q.push_back(cyc);
        end
        if (bus.src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.src_valid && bus.src_ready) begin
            data_q.push_back(int'(bus.src_data));
            sop_q.push_back(int'(bus.src_startofpacket));
            eop_q.push_back(int'(bus.src_endofpacket));
            last_accept_cyc = cyc;
        end
        if (bus.done) begin
            done_seen = done_seen + 1;
            done_cyc  = cyc;
            done_busy = int'(bus.busy);
        end
        if (int'(dut.fifo_count_s) > max_count) max_count = int'(dut.fifo_count_s);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic clear_logs();
        addr_q.delete(); addr_cyc_q.delete(); data_q.delete(); sop_q.delete(); eop_q.delete();
        first_valid_cyc = -1; last_accept_cyc = -1; done_cyc = -1; done_busy = -1;
        done_seen = 0; max_count = 0;
    endtask

    // Runs one transfer. mode 0: ready always high, mode 1: 1-on/3-off.
    // restart_c >= 0 pulses a second start (base 0x500, 3 words) at that loop cycle.
    task automatic run_xfer(input int base, input int cnt, input int mode, input int restart_c,
                            input int budget, output int start_cyc, output int timed_out,
                            output int busy_at_restart);
        clear_logs();
        busy_at_restart = -1;
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.base_addr  = ADDR_W'(base);
        bus.word_count = (ADDR_W+1)'(cnt);
        bus.src_ready  = (mode == 0);
        @(posedge clk); #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        timed_out = 1;
        for (int c = 0; c < budget; c++) begin
            if (mode == 1) bus.src_ready = ((c % 4) == 0);
            if (c == restart_c) begin
                busy_at_restart = int'(bus.busy);
                bus.start       = 1'b1;
                bus.base_addr   = ADDR_W'(32'h500);
                bus.word_count  = (ADDR_W+1)'(3);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_seen > 0) begin
                timed_out = 0;
                break;
            end
        end
        bus.start     = 1'b0;
        bus.src_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_words(input string tag, input int base, input int cnt, input int mode,
                               input int start_cyc);
        int ea;
        check({tag, " addr_count"}, addr_q.size(), cnt);
        check({tag, " word_count"}, data_q.size(), cnt);
        for (int i = 0; i < cnt && i < addr_q.size() && i < data_q.size(); i++) begin
            ea = (base + i) % MEM_WORDS;
            check($sformatf("%s addr[%0d]", tag, i), addr_q[i], ea);
            check($sformatf("%s data[%0d]", tag, i), data_q[i], mem_word(ea));
            check($sformatf("%s sop[%0d]", tag, i), sop_q[i], (i == 0) ? 1 : 0);
            check($sformatf("%s eop[%0d]", tag, i), eop_q[i], (i == cnt - 1) ? 1 : 0);
            if (mode == 0)
                check($sformatf("%s addr_cyc[%0d]", tag, i), addr_cyc_q[i], start_cyc + i);
        end
        if (mode == 0) check({tag, " latency"}, first_valid_cyc - start_cyc, 2);
        check({tag, " done_count"}, done_seen, 1);
        check({tag, " done_after_last"}, done_cyc, last_accept_cyc + 1);
        check({tag, " busy_with_done"}, done_busy, 0);
        check({tag, " fifo_max_le_4"}, (max_count <= 4) ? 1 : 0, 1);
    endtask

    typedef struct {
        int base;
        int cnt;
        int mode;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int sc;
        int to;
        int bar;
        int n_addr;
        int n_data;

        vecs[0] = '{base: 32'h10,  cnt: 4,  mode: 0, exp_first: 32'h10,  exp_last: 32'h13};
        vecs[1] = '{base: 102398,  cnt: 4,  mode: 0, exp_first: 102398,  exp_last: 1};
        vecs[2] = '{base: 32'h100, cnt: 16, mode: 1, exp_first: 32'h100, exp_last: 32'h10F};
        vecs[3] = '{base: 32'h20,  cnt: 1,  mode: 0, exp_first: 32'h20,  exp_last: 32'h20};
        vecs[4] = '{base: 102399,  cnt: 3,  mode: 1, exp_first: 102399,  exp_last: 1};

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.src_ready  = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst cs", bus.mem_chipselect, 0);
        check("rst addr", bus.mem_address, 0);
        check("rst valid", bus.src_valid, 0);
        check("rst sop", bus.src_startofpacket, 0);
        check("rst eop", bus.src_endofpacket, 0);
        check("tie write", bus.mem_write, 0);
        check("tie byteenable", bus.mem_byteenable, 4'hF);
        check("tie clken", bus.mem_clken, 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Table-driven transfers.
        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].mode, -1, 400, sc, to, bar);
            check($sformatf("vec%0d timeout", v), to, 0);
            if (addr_q.size() > 0) begin
                check($sformatf("vec%0d first_addr", v), addr_q[0], vecs[v].exp_first);
                check($sformatf("vec%0d last_addr", v), addr_q[addr_q.size()-1], vecs[v].exp_last);
            end else begin
                check($sformatf("vec%0d any_addr", v), 0, 1);
            end
            check_words($sformatf("vec%0d", v), vecs[v].base, vecs[v].cnt, vecs[v].mode, sc);
        end

        // Zero-length transfer: immediate done, no reads, no words.
        run_xfer(32'h30, 0, 0, -1, 20, sc, to, bar);
        check("zero timeout", to, 0);
        check("zero done_cyc", done_cyc, sc);
        check("zero done_count", done_seen, 1);
        check("zero reads", addr_q.size(), 0);
        check("zero valid_seen", first_valid_cyc, -1);
        check("zero busy", done_busy, 0);

        // Start while busy is ignored.
        run_xfer(32'h200, 8, 1, 3, 400, sc, to, bar);
        check("ign timeout", to, 0);
        check("ign busy_at_start", bar, 1);
        check_words("ign", 32'h200, 8, 1, sc);
        repeat (10) @(posedge clk);
        #1;
        check("ign no_extra_reads", addr_q.size(), 8);
        check("ign idle_busy", bus.busy, 0);

        // Reset at word 5 of a 10-word transfer.
        clear_logs();
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.base_addr  = ADDR_W'(32'h40);
        bus.word_count = (ADDR_W+1)'(10);
        bus.src_ready  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        to = 1;
        for (int c = 0; c < 100; c++) begin
            if (data_q.size() >= 5) begin
                to = 0;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid timeout", to, 0);
        reset = 1'b1;
        #1;
        check("mid busy", bus.busy, 0);
        check("mid done", bus.done, 0);
        check("mid cs", bus.mem_chipselect, 0);
        check("mid addr", bus.mem_address, 0);
        check("mid valid", bus.src_valid, 0);
        check("mid sop", bus.src_startofpacket, 0);
        check("mid eop", bus.src_endofpacket, 0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        n_addr = addr_q.size();
        n_data = data_q.size();
        repeat (20) @(posedge clk);
        #1;
        check("mid no_reads", addr_q.size(), n_addr);
        check("mid no_words", data_q.size(), n_data);
        check("mid no_done", done_seen, 0);
        bus.src_ready = 1'b0;

        run_xfer(32'h80, 2, 0, -1, 100, sc, to, bar);
        check("post timeout", to, 0);
        check_words("post", 32'h80, 2, 0, sc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
